// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: shared FSM encoding and geometry check for multi-cycle arithmetic blocks
package seq_chunk_adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic bit chunk_fits(input int width, input int chunk);
    return chunk > 0 && width % chunk == 0;
  endfunction
endpackage

// File: rtl/seq_chunk_adder_rca.sv
// rca_chunk: CHUNK-bit ripple-carry adder built from full-adder cells
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_chunk #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  assign cout = c[N];
  for (genvar i = 0; i < N; i++) begin : g_fa
    fulladder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
  end
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor processing CHUNK bits per clock, LSB chunk first
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NUM_STEPS = WIDTH / CHUNK;
  localparam int SW = NUM_STEPS > 1 ? $clog2(NUM_STEPS) : 1;
  if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_geometry
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end
  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic             c_c, last;
  assign a_c  = a_q[step_q*CHUNK +: CHUNK];
  assign b_c  = b_q[step_q*CHUNK +: CHUNK];
  assign last = step_q == SW'(NUM_STEPS - 1);
  rca_chunk #(.N(CHUNK)) u_rca (.a(a_c), .b(b_c), .cin(carry_q), .sum(s_c), .cout(c_c));
  // Next state: accept operands in IDLE, one chunk per BUSY cycle, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && in_valid) begin
      state_d = BUSY;
      step_d  = '0;
      a_d     = A;
      b_d     = sub ? ~B : B;
      sum_d   = '0;
      carry_d = sub | cin;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == BUSY) begin
      sum_d[step_q*CHUNK +: CHUNK] = s_c;
      carry_d = c_c;
      step_d  = last ? '0 : step_q + 1'b1;
      if (last) begin
        state_d = DONE;
        cout_d  = c_c;
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign Sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: scoreboard bench over CHUNK=8, 32 and 4 instances sharing one stimulus bus
module tb_seq_chunk_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  int          sel = 0;
  logic [2:0]  iv, orr, ir, ov, co, of;
  logic [31:0] sm [3];
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] Sum;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [33:0] sb [$];
  localparam int NS [3] = '{4, 1, 8};

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_sel
    assign iv[k]  = in_valid && sel == k;
    assign orr[k] = out_ready && sel == k;
  end
  assign in_ready  = ir[sel];
  assign out_valid = ov[sel];
  assign Sum       = sm[sel];
  assign cout      = co[sel];
  assign ovf       = of[sel];

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(orr[0]), .Sum(sm[0]), .cout(co[0]), .ovf(of[0]));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(orr[1]), .Sum(sm[1]), .cout(co[1]), .ovf(of[1]));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(orr[2]), .Sum(sm[2]), .cout(co[2]), .ovf(of[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    logic [31:0] be;
    logic [32:0] full;
    be   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {32'd0, s | c};
    return {full[32], (a[31] == be[31]) && (full[31] != a[31]), full[31:0]};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s, input bit push);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check("in_ready_timeout", 0, 1);
    A = a; B = b; cin = c; sub = s; in_valid = 1'b1;
    if (push) sb.push_back(model(a, b, c, s));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int lat = 0;
    logic [33:0] e;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, NS[sel]);
    e = sb.size() > 0 ? sb.pop_front() : 34'h3_dead_beef;
    check({tag, "_sum"}, Sum, e[31:0]);
    check({tag, "_cout"}, cout, e[33]);
    check({tag, "_ovf"}, ovf, e[32]);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    send(32'hFFFF_FFFF, 32'h1, 0, 0, 1); collect("add_wrap");
    check("idle_after_take", in_ready, 1);
    check("ov_one_wide", out_valid, 0);
    send(32'h7FFF_FFFF, 32'h1, 0, 0, 1); collect("add_ovf");
    send(32'h1234_5678, 32'h1111_1111, 1, 0, 1); collect("add_cin");
    send(32'd5, 32'd7, 1, 1, 1); collect("sub_neg");
    send(32'h8000_0000, 32'h1, 0, 1, 1); collect("sub_ovf");
    out_ready = 1'b0;
    send(32'h1, 32'h2, 0, 0, 1); collect("bp");
    for (int i = 0; i < 10; i++) begin
      A = 32'hDEAD_0000 + i; B = 32'h0BAD_F00D; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", Sum, 3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1 check("bp_dropped", out_valid, 0);
    send(32'hAAAA_AAAA, 32'h5555_5555, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", Sum, 0);
    send(32'd3, 32'd4, 0, 0, 1); collect("after_rst");
    sel = 1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1); collect("c32");
    sel = 2;
    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom), 1); collect("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle ripple-carry adder/subtractor, successor to the fixed 8-bit structural ripple adder. Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through one registered CHUNK-bit ripple chain, and carries the inter-chunk carry in a register. Valid/ready handshakes on input and output let it sit between datapath stages that trade latency for area.

## Interface
- WIDTH, 32: operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; NUM_STEPS = WIDTH/CHUNK.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands, mode and cin are valid.
- in_ready  output  1  block is idle and accepts operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  0: A+B+cin, 1: A−B.
- out_valid  output  1  result registers hold a complete result.
- out_ready  input  1  consumer takes the result.
- Sum  output  WIDTH  result.
- cout  output  1  final carry out (sub: 1 means no borrow).
- ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid && in_ready, latch A, B_eff = sub ? ~B : B, carry = sub ? 1 : cin, step = 0, Sum cleared; go to BUSY.
- BUSY: per cycle, add chunk[step] of A and B_eff with carry; write CHUNK result bits into Sum[step*CHUNK +: CHUNK]; carry <= chunk carry-out; step++. After the step NUM_STEPS−1 cycle, go to DONE.
- DONE: cout = final carry; ovf = (A[WIDTH−1] == B_eff[WIDTH−1]) && (Sum[WIDTH−1] != A[WIDTH−1]). Hold Sum/cout/ovf stable until out_ready, then go to IDLE.
- Arithmetic: modulo 2^WIDTH; no saturation. Sum bits are not yet-valid until out_valid.
- in_valid while not IDLE is ignored; operands are not queued.
- Reset (any state, including mid-BUSY): state IDLE, step 0, carry 0, Sum 0, cout 0, ovf 0; in-flight operation abandoned, no out_valid produced.

## Timing
- Reset values: in_ready 1 (state IDLE), out_valid 0, Sum 0, cout 0, ovf 0.
- Accept at edge T0 → out_valid high after edge T0+NUM_STEPS (latency NUM_STEPS cycles).
- out_ready high in the first DONE cycle → out_valid one cycle wide, IDLE at next edge; next accept possible one cycle later. Peak throughput: one result per NUM_STEPS+2 cycles.
- out_ready low: DONE held indefinitely, outputs constant, in_ready 0.
- CHUNK==WIDTH: NUM_STEPS=1, single BUSY cycle.
- Critical path: one CHUNK-bit ripple chain plus carry register; independent of WIDTH.

## Structure
- Shared package/header: FSM state encodings (IDLE/BUSY/DONE) and the WIDTH%CHUNK==0 elaboration check, reused by later multi-cycle arithmetic blocks.
- One sub-module: rca_chunk (parametrised CHUNK-bit ripple adder built from the existing fulladder cell, ports a, b, cin, sum, cout). Top holds FSM, step counter, operand/carry/result registers, and chunk mux.

## Test plan
- WIDTH=32, CHUNK=8, add A=0xFFFFFFFF, B=0x00000001, cin=0 → Sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- Add A=0x7FFFFFFF, B=0x00000001, cin=0 → Sum=0x80000000, cout=0, ovf=1; add A=0x12345678, B=0x11111111, cin=1 → Sum=0x2345678A, cout=0, ovf=0.
- Sub A=5, B=7, cin=1 (ignored) → Sum=0xFFFFFFFE, cout=0, ovf=0; sub A=0x80000000, B=1 → Sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: out_ready low 10 cycles in DONE, in_valid pulsed with new operands → outputs unchanged, in_ready 0, new operands dropped; out_ready high → one result, then IDLE.
- rst asserted during BUSY step 2 → next cycle in_ready=1, out_valid=0, Sum=0; a following add 3+4 yields Sum=7, cout=0.
- CHUNK=32 instance: add 0xFFFFFFFF+0xFFFFFFFF → Sum=0xFFFFFFFE, cout=1, latency 1 cycle; random add/sub vs. reference model, 1000 ops, CHUNK=4.
